// File: rtl/lc3_pkg.sv
// Shared LC-3 control encodings: opcodes, ALU and mux select codes, and the
// ISDU state enum used by the sequencer and its debug port.
package lc3_pkg;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  typedef enum logic [4:0] {
    ST_HALTED, ST_F_MAR, ST_F_RD, ST_F_IR, ST_DECODE,
    ST_ADD, ST_AND, ST_NOT,
    ST_LDR_MAR, ST_LDR_RD, ST_LDR_WB,
    ST_STR_MAR, ST_STR_MDR, ST_STR_WR,
    ST_JSR_SAVE, ST_JSR_PC, ST_JMP,
    ST_BR_TEST, ST_BR_TAKE,
    ST_PAUSE_HI, ST_PAUSE_LO
  } isdu_state_e;

  // States that hold a memory strobe for MEM_WAIT+1 cycles.
  function automatic logic is_mem_state(input isdu_state_e s);
    return (s == ST_F_RD) || (s == ST_LDR_RD) || (s == ST_STR_WR);
  endfunction

endpackage

// File: rtl/lc3_isdu_if.sv
// LC-3 ISDU control bus: front-panel and datapath inputs plus every load,
// gate, mux select and memory strobe the sequencer drives.
interface lc3_isdu_if;
  // No valid/ready handshake here: Run and Continue are level-sampled
  // buttons, and every output is a per-cycle strobe valid for that cycle only.
  logic        Run;
  logic        Continue;
  logic [15:0] IR;
  logic        BEN;

  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic Mem_OE, Mem_WE;
  logic Pause_Active;

  modport master (
    input  Run, Continue, IR, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_OE, Mem_WE, Pause_Active
  );

  modport slave (
    output Run, Continue, IR, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_OE, Mem_WE, Pause_Active
  );
endinterface

// File: rtl/lc3_isdu_waitctr.sv
// Memory wait counter: counts cycles spent in a memory state and flags the
// last one (count == MEM_WAIT). Clear restarts the count at zero.
module lc3_isdu_waitctr #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic done_o
);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = clr_i ? 3'd0 : count_q + 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= 3'd0;
    else          count_q <= count_d;
  end

  assign done_o = (count_q == 3'(MEM_WAIT));

endmodule

// File: rtl/lc3_isdu.sv
// Multi-cycle LC-3 instruction sequencer/decoder. Outputs decode the state
// register directly. Define ISDU_PAUSE_EN to build the opcode-1101 pause states.
module lc3_isdu
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  lc3_isdu_if.master        bus,
  output isdu_state_e       state_dbg_o
);

  isdu_state_e state_q, state_d;
  logic        wait_clr, wait_done;

  // Counter sits at zero outside memory states, so every entry starts fresh.
  assign wait_clr = !is_mem_state(state_q) || wait_done;

  lc3_isdu_waitctr #(.MEM_WAIT(MEM_WAIT)) u_waitctr (
    .clk_i   (Clk),
    .rst_n_i (Reset_n),
    .clr_i   (wait_clr),
    .done_o  (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED:   if (bus.Run) state_d = ST_F_MAR;
      ST_F_MAR:    state_d = ST_F_RD;
      ST_F_RD:     if (wait_done) state_d = ST_F_IR;
      ST_F_IR:     state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.IR[15:12])
          OP_ADD:   state_d = ST_ADD;
          OP_AND:   state_d = ST_AND;
          OP_NOT:   state_d = ST_NOT;
          OP_LDR:   state_d = ST_LDR_MAR;
          OP_STR:   state_d = ST_STR_MAR;
          OP_JSR:   state_d = bus.IR[11] ? ST_JSR_SAVE : ST_F_MAR;
          OP_JMP:   state_d = ST_JMP;
          OP_BR:    state_d = ST_BR_TEST;
`ifdef ISDU_PAUSE_EN
          OP_PAUSE: state_d = ST_PAUSE_HI;
`endif
          default:  state_d = ST_F_MAR;
        endcase
      end
      ST_ADD, ST_AND, ST_NOT: state_d = ST_F_MAR;
      ST_LDR_MAR:  state_d = ST_LDR_RD;
      ST_LDR_RD:   if (wait_done) state_d = ST_LDR_WB;
      ST_LDR_WB:   state_d = ST_F_MAR;
      ST_STR_MAR:  state_d = ST_STR_MDR;
      ST_STR_MDR:  state_d = ST_STR_WR;
      ST_STR_WR:   if (wait_done) state_d = ST_F_MAR;
      ST_JSR_SAVE: state_d = ST_JSR_PC;
      ST_JSR_PC:   state_d = ST_F_MAR;
      ST_JMP:      state_d = ST_F_MAR;
      ST_BR_TEST:  state_d = bus.BEN ? ST_BR_TAKE : ST_F_MAR;
      ST_BR_TAKE:  state_d = ST_F_MAR;
`ifdef ISDU_PAUSE_EN
      // Two-phase handshake so one held button releases exactly one pause.
      ST_PAUSE_HI: if (bus.Continue) state_d = ST_PAUSE_LO;
      ST_PAUSE_LO: if (!bus.Continue) state_d = ST_F_MAR;
`endif
      default:     state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_HALTED;
    else          state_q <= state_d;
  end

  assign state_dbg_o = state_q;

  always_comb begin
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = PCMUX_INC;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.ALUK       = ALUK_ADD;
    bus.Mem_OE     = 1'b0;
    bus.Mem_WE     = 1'b0;
    case (state_q)
      ST_F_MAR: begin
        bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.LD_PC = 1'b1; bus.PCMUX = PCMUX_INC;
      end
      ST_F_RD, ST_LDR_RD: begin
        bus.Mem_OE = 1'b1; bus.LD_MDR = 1'b1;
      end
      ST_F_IR:   begin bus.GateMDR = 1'b1; bus.LD_IR = 1'b1; end
      ST_DECODE: bus.LD_BEN = 1'b1;
      ST_ADD, ST_AND, ST_NOT: begin
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = bus.IR[5];
        bus.ALUK    = (state_q == ST_ADD) ? ALUK_ADD :
                      (state_q == ST_AND) ? ALUK_AND : ALUK_NOT;
        bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      // Base register lives in IR[8:6], so SR1 must point there for ADDR1MUX=1.
      ST_LDR_MAR, ST_STR_MAR: begin
        bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_OFF6;
        bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
      end
      ST_LDR_WB: begin
        bus.GateMDR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      ST_STR_MDR: begin
        bus.SR1MUX = 1'b0; bus.ALUK = ALUK_PASSA; bus.GateALU = 1'b1; bus.LD_MDR = 1'b1;
      end
      ST_STR_WR:   bus.Mem_WE = 1'b1;
      ST_JSR_SAVE: begin bus.GatePC = 1'b1; bus.DRMUX = 1'b1; bus.LD_REG = 1'b1; end
      ST_JSR_PC: begin
        bus.ADDR2MUX = ADDR2_OFF11; bus.ADDR1MUX = 1'b0; bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
      end
      ST_JMP: begin
        bus.SR1MUX = 1'b1; bus.ALUK = ALUK_PASSA; bus.GateALU = 1'b1;
        bus.PCMUX = PCMUX_BUS; bus.LD_PC = 1'b1;
      end
      ST_BR_TAKE: begin
        bus.ADDR2MUX = ADDR2_OFF9; bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ISDU_PAUSE_EN
  assign bus.Pause_Active = (state_q == ST_PAUSE_HI) || (state_q == ST_PAUSE_LO);
`else
  logic unused_continue;
  assign unused_continue  = bus.Continue;
  assign bus.Pause_Active = 1'b0;
`endif

  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.IR[10:6], bus.IR[4:0]};

endmodule

// File: tb/tb_lc3_isdu.sv
// Bench for lc3_isdu: per-instruction micro-op model feeding an expected
// queue, compared cycle by cycle; honours ISDU_PAUSE_EN when defined.
module tb_lc3_isdu;
  import lc3_pkg::*;

  localparam int MW = 2;

  // Observation vector layout (bench-owned):
  // 23 LD_MAR 22 LD_MDR 21 LD_IR 20 LD_BEN 19 LD_CC 18 LD_REG 17 LD_PC
  // 16 GatePC 15 GateMDR 14 GateALU 13 GateMARMUX 12:11 PCMUX 10 DRMUX
  // 9 SR1MUX 8 SR2MUX 7 ADDR1MUX 6:5 ADDR2MUX 4:3 ALUK 2 Mem_OE 1 Mem_WE 0 Pause
  localparam logic [23:0] C_LD_MAR  = 24'h800000, C_LD_MDR = 24'h400000;
  localparam logic [23:0] C_LD_IR   = 24'h200000, C_LD_BEN = 24'h100000;
  localparam logic [23:0] C_LD_CC   = 24'h080000, C_LD_REG = 24'h040000;
  localparam logic [23:0] C_LD_PC   = 24'h020000, C_G_PC   = 24'h010000;
  localparam logic [23:0] C_G_MDR   = 24'h008000, C_G_ALU  = 24'h004000;
  localparam logic [23:0] C_G_MARMUX= 24'h002000;
  localparam logic [23:0] C_PC_BUS  = 24'h000800, C_PC_ADDER = 24'h001000;
  localparam logic [23:0] C_DRMUX   = 24'h000400, C_SR1MUX = 24'h000200;
  localparam logic [23:0] C_SR2MUX  = 24'h000100, C_ADDR1  = 24'h000080;
  localparam logic [23:0] C_A2_OFF6 = 24'h000020, C_A2_OFF9 = 24'h000040, C_A2_OFF11 = 24'h000060;
  localparam logic [23:0] C_ALU_AND = 24'h000008, C_ALU_NOT = 24'h000010, C_ALU_PASSA = 24'h000018;
  localparam logic [23:0] C_MEM_OE  = 24'h000004, C_MEM_WE = 24'h000002, C_PAUSE = 24'h000001;
  localparam logic [23:0] C_FETCH_MAR = C_G_PC | C_LD_MAR | C_LD_PC;

  logic        Clk;
  logic        Reset_n;
  isdu_state_e state_dbg;
  int          n_cmp;
  int          n_err;
  logic [23:0] exp_q[$];

  lc3_isdu_if bus ();

  lc3_isdu #(.MEM_WAIT(MW)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] obs();
    return {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC, bus.LD_REG, bus.LD_PC,
            bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX, bus.PCMUX, bus.DRMUX,
            bus.SR1MUX, bus.SR2MUX, bus.ADDR1MUX, bus.ADDR2MUX, bus.ALUK,
            bus.Mem_OE, bus.Mem_WE, bus.Pause_Active};
  endfunction

  // ---------------- reference model ----------------
  // Each instruction expands to its list of per-cycle micro-ops.
  task automatic model_push(input logic [15:0] ir, input logic ben);
    logic [23:0] alu_op;
    logic [23:0] addr_calc;
    alu_op    = C_SR1MUX | (ir[5] ? C_SR2MUX : 24'h0) | C_G_ALU | C_LD_REG | C_LD_CC;
    addr_calc = C_SR1MUX | C_ADDR1 | C_A2_OFF6 | C_G_MARMUX | C_LD_MAR;
    exp_q.push_back(C_FETCH_MAR);
    for (int i = 0; i <= MW; i++) exp_q.push_back(C_MEM_OE | C_LD_MDR);
    exp_q.push_back(C_G_MDR | C_LD_IR);
    exp_q.push_back(C_LD_BEN);
    case (ir[15:12])
      4'h1: exp_q.push_back(alu_op);
      4'h5: exp_q.push_back(alu_op | C_ALU_AND);
      4'h9: exp_q.push_back(alu_op | C_ALU_NOT);
      4'h6: begin
        exp_q.push_back(addr_calc);
        for (int i = 0; i <= MW; i++) exp_q.push_back(C_MEM_OE | C_LD_MDR);
        exp_q.push_back(C_G_MDR | C_LD_REG | C_LD_CC);
      end
      4'h7: begin
        exp_q.push_back(addr_calc);
        exp_q.push_back(C_ALU_PASSA | C_G_ALU | C_LD_MDR);
        for (int i = 0; i <= MW; i++) exp_q.push_back(C_MEM_WE);
      end
      4'h4: if (ir[11]) begin
        exp_q.push_back(C_G_PC | C_DRMUX | C_LD_REG);
        exp_q.push_back(C_A2_OFF11 | C_PC_ADDER | C_LD_PC);
      end
      4'hC: exp_q.push_back(C_SR1MUX | C_ALU_PASSA | C_G_ALU | C_PC_BUS | C_LD_PC);
      4'h0: begin
        exp_q.push_back(24'h0);
        if (ben) exp_q.push_back(C_A2_OFF9 | C_PC_ADDER | C_LD_PC);
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic restart();
    @(negedge Clk);
    bus.Run = 1'b0;
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    bus.Run = 1'b1;
  endtask

  // Inputs change just after the edge that enters F_MAR.
  task automatic start_instr(input logic [15:0] ir, input logic ben);
    @(posedge Clk);
    #1;
    bus.IR  = ir;
    bus.BEN = ben;
    model_push(ir, ben);
  endtask

  task automatic measure_cycles(input logic [15:0] ir, input logic ben, output int n);
    restart();
    @(posedge Clk);
    #1;
    bus.IR  = ir;
    bus.BEN = ben;
    n = 0;
    @(negedge Clk);
    do begin
      @(negedge Clk);
      n++;
    end while (obs() !== C_FETCH_MAR && n < 64);
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain(input string tag, output int we_seen);
    logic [23:0] exp_v, got_v;
    int cyc;
    cyc = 0;
    we_seen = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got_v, exp_v);
      end
      if (got_v[1]) we_seen++;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if (obs() !== 24'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", obs(), 24'h0);
    end
    n_cmp++;
    if (state_dbg !== ST_HALTED) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_HALTED);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (obs() !== 24'h0 || state_dbg !== ST_HALTED) begin
      n_err++; $display("FAIL halted_without_run: got %h/%0d expected 0/%0d", obs(), state_dbg, ST_HALTED);
    end
  endtask

  task automatic test_reset_mid_read();
    restart();
    @(posedge Clk);
    #1;
    bus.IR = 16'h1261;
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++;
    if (bus.Mem_OE !== 1'b1) begin
      n_err++; $display("FAIL mid_read_oe: got %b expected 1", bus.Mem_OE);
    end
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.Mem_OE !== 1'b0 || obs() !== 24'h0) begin
      n_err++; $display("FAIL async_reset_outputs: got %h expected %h", obs(), 24'h0);
    end
    n_cmp++;
    if (state_dbg !== ST_HALTED) begin
      n_err++; $display("FAIL async_reset_state: got %0d expected %0d", state_dbg, ST_HALTED);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    bus.Run = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (obs() !== C_FETCH_MAR) begin
      n_err++; $display("FAIL restart_fetch: got %h expected %h", obs(), C_FETCH_MAR);
    end
  endtask

  task automatic test_add();
    int we, n;
    restart();
    start_instr(16'h1261, 1'b0);
    drain("add", we);
    @(negedge Clk);
    n_cmp++;
    if (obs() !== C_FETCH_MAR) begin
      n_err++; $display("FAIL add_next_fetch: got %h expected %h", obs(), C_FETCH_MAR);
    end
    measure_cycles(16'h1261, 1'b0, n);
    n_cmp++;
    if (n !== 5 + MW) begin
      n_err++; $display("FAIL add_cycles: got %0d expected %0d", n, 5 + MW);
    end
  endtask

  task automatic test_str();
    int we;
    restart();
    start_instr(16'h7442, 1'b0);
    drain("str", we);
    n_cmp++;
    if (we !== MW + 1) begin
      n_err++; $display("FAIL str_we_cycles: got %0d expected %0d", we, MW + 1);
    end
  endtask

  task automatic test_branch();
    int we, n;
    restart();
    start_instr(16'h0402, 1'b0);
    drain("br_not_taken", we);
    start_instr(16'h0402, 1'b1);
    drain("br_taken", we);
    measure_cycles(16'h0402, 1'b1, n);
    n_cmp++;
    if (n !== 6 + MW) begin
      n_err++; $display("FAIL br_taken_cycles: got %0d expected %0d", n, 6 + MW);
    end
    measure_cycles(16'h0402, 1'b0, n);
    n_cmp++;
    if (n !== 5 + MW) begin
      n_err++; $display("FAIL br_not_taken_cycles: got %0d expected %0d", n, 5 + MW);
    end
  endtask

  task automatic test_illegal();
    int we, n;
    restart();
    start_instr(16'hA000, 1'b0);
    drain("illegal", we);
    measure_cycles(16'hA000, 1'b0, n);
    n_cmp++;
    if (n !== 4 + MW) begin
      n_err++; $display("FAIL illegal_cycles: got %0d expected %0d", n, 4 + MW);
    end
  endtask

  task automatic test_pause();
    int we, n;
`ifdef ISDU_PAUSE_EN
    int k, h;
    restart();
    bus.Continue = 1'b0;
    start_instr(16'hD0FF, 1'b0);
    drain("pause_fetch", we);
    k = $urandom_range(1, 5);
    for (int i = 0; i < k; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (obs() !== C_PAUSE) begin
        n_err++; $display("FAIL pause_hi: got %h expected %h", obs(), C_PAUSE);
      end
    end
    bus.Continue = 1'b1;
    h = $urandom_range(2, 5);
    for (int i = 0; i < h; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (obs() !== C_PAUSE || state_dbg !== ST_PAUSE_LO) begin
        n_err++; $display("FAIL pause_lo_hold: got %h/%0d expected %h/%0d", obs(), state_dbg, C_PAUSE, ST_PAUSE_LO);
      end
    end
    bus.Continue = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (obs() !== C_FETCH_MAR) begin
      n_err++; $display("FAIL pause_release: got %h expected %h", obs(), C_FETCH_MAR);
    end
`else
    restart();
    bus.Continue = 1'b0;
    start_instr(16'hD0FF, 1'b0);
    drain("pause_as_nop", we);
    measure_cycles(16'hD0FF, 1'b0, n);
    n_cmp++;
    if (n !== 4 + MW) begin
      n_err++; $display("FAIL pause_nop_cycles: got %0d expected %0d", n, 4 + MW);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[$];
    logic [15:0] ir;
    logic        ben;
    int          we;
    ops = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hC,
            4'h2, 4'h3, 4'h8, 4'hA, 4'hB, 4'hE, 4'hF};
`ifndef ISDU_PAUSE_EN
    ops.push_back(4'hD);
`endif
    restart();
    for (int i = 0; i < 40; i++) begin
      ir  = {ops[$urandom_range(0, ops.size() - 1)], 12'($urandom_range(0, 4095))};
      ben = 1'($urandom_range(0, 1));
      start_instr(ir, ben);
      drain("random", we);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    Reset_n      = 1'b0;
    bus.Run      = 1'b0;
    bus.Continue = 1'b0;
    bus.IR       = 16'h0;
    bus.BEN      = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    test_reset_mid_read();
    test_add();
    test_str();
    test_branch();
    test_illegal();
    test_pause();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
